// File: rtl/arb_pkg.sv
// Shared sizes, FSM state encoding and helpers for the 4-way round-robin arbiter.
package arb_pkg;

    localparam int N_REQ  = 4;
    localparam int ID_W   = 2;
    localparam int HOLD_W = 8;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_OWNED = 1'b1
    } arb_state_e;

    function automatic logic [N_REQ-1:0] id_to_onehot(input logic [ID_W-1:0] id);
        logic [N_REQ-1:0] one;
        one     = '0;
        one[id] = 1'b1;
        return one;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin winner select: first set req bit strictly after last_id, wrapping.
module rr_pick
    import arb_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  last_id,
    output logic [N_REQ-1:0] win,
    output logic [ID_W-1:0]  win_id,
    output logic             any
);

    logic             found;
    logic [ID_W-1:0]  idx;

    always_comb begin
        found  = 1'b0;
        idx    = '0;
        win_id = '0;
        any    = |req;
        // ID_W-bit addition wraps 3 -> 0 for free.
        for (int k = 1; k <= N_REQ; k++) begin
            idx = last_id + ID_W'(k);
            if (!found && req[idx]) begin
                found  = 1'b1;
                win_id = idx;
            end
        end
        win = any ? id_to_onehot(win_id) : '0;
    end

endmodule

// File: rtl/round_robin_arbiter_4.sv
// Four-requester round-robin arbiter with registered one-hot grant and MAX_HOLD revocation.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_IDLE  | no owner; grant is zero; any request is granted at next edge
// ST_OWNED | one requester holds grant; hold_cnt counts its owned cycles
module round_robin_arbiter_4
    import arb_pkg::*;
#(
    parameter int MAX_HOLD = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] grant,
    output logic [ID_W-1:0]  grant_id,
    output logic             busy,
    output logic             timeout
);

    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);
    localparam logic [HOLD_W-1:0] HOLD_SAT  = '1;

    arb_state_e        state_q, state_d;
    logic [N_REQ-1:0]  grant_q, grant_d;
    logic [ID_W-1:0]   grant_id_q, grant_id_d;
    logic              busy_q, busy_d;
    logic              timeout_q, timeout_d;
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    logic [ID_W-1:0]   last_id_q, last_id_d;

    logic [N_REQ-1:0]  pick_win;
    logic [ID_W-1:0]   pick_id;
    logic              pick_any;

    rr_pick u_pick (
        .req     (req),
        .last_id (last_id_q),
        .win     (pick_win),
        .win_id  (pick_id),
        .any     (pick_any)
    );

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        grant_id_d = grant_id_q;
        busy_d     = busy_q;
        timeout_d  = 1'b0;
        hold_cnt_d = hold_cnt_q;
        last_id_d  = last_id_q;

        case (state_q)
            ST_IDLE: begin
                grant_d    = '0;
                grant_id_d = '0;
                busy_d     = 1'b0;
                hold_cnt_d = '0;
                if (pick_any) begin
                    state_d    = ST_OWNED;
                    grant_d    = pick_win;
                    grant_id_d = pick_id;
                    busy_d     = 1'b1;
                    last_id_d  = pick_id;
                end
            end
            ST_OWNED: begin
                // Release is checked first so a drop on the expiry edge never pulses timeout.
                if (!req[grant_id_q] || (hold_cnt_q == HOLD_LAST)) begin
                    state_d    = ST_IDLE;
                    grant_d    = '0;
                    grant_id_d = '0;
                    busy_d     = 1'b0;
                    hold_cnt_d = '0;
                    timeout_d  = req[grant_id_q];
                end else if (hold_cnt_q != HOLD_SAT) begin
                    hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                end
            end
            default: begin
                state_d    = ST_IDLE;
                grant_d    = '0;
                grant_id_d = '0;
                busy_d     = 1'b0;
                hold_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            grant_q    <= '0;
            grant_id_q <= '0;
            busy_q     <= 1'b0;
            timeout_q  <= 1'b0;
            hold_cnt_q <= '0;
            last_id_q  <= ID_W'(N_REQ - 1);
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            grant_id_q <= grant_id_d;
            busy_q     <= busy_d;
            timeout_q  <= timeout_d;
            hold_cnt_q <= hold_cnt_d;
            last_id_q  <= last_id_d;
        end
    end

    assign grant    = grant_q;
    assign grant_id = grant_id_q;
    assign busy     = busy_q;
    assign timeout  = timeout_q;

endmodule

// File: doc/round_robin_arbiter_4.md
ROUND_ROBIN_ARBITER_4 -- requirements
Module: round_robin_arbiter_4

Interface
REQ-001 SHALL provide parameter MAX_HOLD, default 8, maximum consecutive cycles one requester may hold grant (legal range 2..255).
REQ-002 SHALL provide port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL provide port rst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL provide port req  input  4  request lines; req[i] held high while requester i needs the shared resource.
REQ-005 SHALL provide port grant  output  4  registered one-hot grant; all-zero when no owner.
REQ-006 SHALL provide port grant_id  output  2  binary index of current owner; 0 when grant is all-zero.
REQ-007 SHALL provide port busy  output  1  high exactly when grant is non-zero.
REQ-008 SHALL provide port timeout  output  1  one-cycle pulse when a grant is revoked by MAX_HOLD expiry.

Function
REQ-009 SHALL implement FSM states IDLE and OWNED; grant non-zero only in OWNED.
REQ-010 SHALL, in IDLE with any req bit high at a rising edge, enter OWNED at that edge with grant set to the winner (1-cycle latency req->grant).
REQ-011 SHALL select the winner round-robin: first set req bit scanning upward from (last_id+1) mod 4, wrapping 3->0.
REQ-012 SHALL update last_id to the winner on every grant issue; last_id resets to 3 so req[0] has first priority after reset.
REQ-013 SHALL, in IDLE with req == 0, remain in IDLE with all outputs zero.
REQ-014 SHALL keep grant constant in OWNED while req[grant_id] stays high and hold count is below MAX_HOLD; other req bits have no effect.
REQ-015 SHALL, when req[grant_id] is low at a rising edge in OWNED, return to IDLE with grant cleared at that edge (voluntary release).
REQ-016 SHALL count owned cycles in hold_cnt (width 8), cleared on entry to OWNED, incremented each OWNED cycle, never wrapping.
REQ-017 SHALL, when hold_cnt reaches MAX_HOLD-1 with req[grant_id] still high, clear grant at the next edge, return to IDLE and pulse timeout high for that one cycle.
REQ-018 SHALL guarantee at least one all-zero grant cycle between any two grants, including re-grant to the same requester.
REQ-019 SHALL give release precedence over timeout when both occur on the same edge (timeout stays low).
REQ-020 SHALL, after timeout with only the revoked requester active, re-grant it after the one dead cycle.
REQ-021 SHALL never assert more than one grant bit and never grant a requester whose req bit was low at the issuing edge.

Reset
REQ-022 SHALL, on rst_n low, immediately force state IDLE, grant 0, grant_id 0, busy 0, timeout 0, hold_cnt 0, last_id 3, regardless of clock.
REQ-023 SHALL, on reset assertion mid-grant, drop grant asynchronously and restart arbitration from req[0] priority after rst_n deassertion.

Structure
REQ-024 SHALL place N_REQ (4), ID_W (2), HOLD_W (8) and the FSM state enumeration in shared package arb_pkg.
REQ-025 SHALL isolate winner selection in combinational sub-module rr_pick (inputs req, last_id; outputs one-hot win, win_id, any).

Verification
REQ-026 SHALL cover: reset release, req=4'b0001 -> grant=4'b0001, grant_id=0, busy=1 one cycle later.
REQ-027 SHALL cover: req=4'b1111 held, each holder releases after 2 cycles -> grant order 0001,0010,0100,1000,0001 with one zero cycle between each.
REQ-028 SHALL cover: MAX_HOLD=8, req=4'b0100 held continuously -> grant=0100 for exactly 8 cycles, timeout pulse, one zero cycle, grant=0100 again.
REQ-029 SHALL cover: owner 1 times out while req=4'b0110 -> next grant=4'b0100, not 0010.
REQ-030 SHALL cover: owner drops req on the same edge hold_cnt hits MAX_HOLD-1 -> grant clears, timeout=0.
REQ-031 SHALL cover: rst_n pulled low mid-cycle while grant=4'b1000 -> grant=0 without clock edge; after release with req=4'b1001 -> grant=4'b0001.
